shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Multi-cycle controller that executes ARMv7 register-specified shifts (8-bit amount from Rs[7:0]) using the shared 5-bit barrel `Shifter`, including ARM carry-out semantics. It sits between decode/register-read and the ALU operand-2 path. It drives the shifter's Amount/Type/In inputs, registers the shifter's Out each cycle, and reports Out/CarryOut with a start/done handshake.

## Interface
- No parameters.
- CLK  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  request; accepted only when Busy=0.
- Type  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR; sampled on accept.
- Amount  input  8  shift amount 0..255; sampled on accept.
- In  input  32  operand; sampled on accept.
- CarryIn  input  1  current CPSR.C; sampled on accept.
- Busy  output  1  high whenever state≠IDLE.
- Done  output  1  one-cycle pulse; Out/CarryOut valid.
- Out  output  32  result (= Acc register); held until the next accept.
- CarryOut  output  1  shifter carry; held until the next accept.
- Sh_Amount  output  5  to Shifter.Amount.
- Sh_Type  output  2  to Shifter.Type (latched Type).
- Sh_In  output  32  to Shifter.In (= Acc).
- Sh_Out  input  32  from Shifter.Out.

## Operation
- Registers: state, Acc[31:0], T[1:0], Rem[5:0], C, CIn.
- States: IDLE, BULK, LAST, DONE.
- Accept, in IDLE with Start=1: Acc←In, T←Type, CIn←CarryIn. Compute the effective amount E:
  - Type≠ROR: E = min(Amount,33).
  - ROR: E = Amount[4:0].
- Special cases go IDLE→DONE:
  - Amount==0: C←CarryIn.
  - ROR with Amount≠0 and Amount[4:0]==0: C←In[31].
- Otherwise Rem←E−1, then go to BULK if E>1, else to LAST.
- BULK: Sh_Amount=min(Rem,31). Acc←Sh_Out, Rem←Rem−step. Go to LAST when Rem−step==0.
- LAST: Sh_Amount=1. C←(T==LSL) ? Acc[31] : Acc[0], where Acc is the value before the step. Acc←Sh_Out. Go to DONE.
- DONE: Done=1. Go to IDLE.
- Sh_Amount=0 in IDLE and DONE.
- Start is ignored while Busy=1. No queuing.
- Resulting ARM semantics:
  - LSL 32: Out 0, C=In[0]. LSL >32: 0/0.
  - LSR 32: Out 0, C=In[31]. LSR >32: 0/0.
  - ASR ≥32: sign-fill, C=In[31].
  - ROR: Out=ror(In,Amount[4:0]), C=Out[31].

## Timing
- Reset, async and immediate: state=IDLE, Acc/Out=0, CarryOut=0, Done=0, Busy=0, Sh_Amount=0, Sh_Type=0. Reset mid-operation aborts; the in-flight result is lost.
- Shift cycles: k = ceil((E−1)/31) + 1 for E≥1.
- Latency, from the accept edge to the first cycle with Done=1:
  - k+1 cycles.
  - Special cases: 1 cycle.
- Examples: E=1 → 2 cycles. E=32 → 3 cycles. E=33 → 4 cycles (maximum).
- Busy rises the cycle after accept and stays high through DONE. The next Start is accepted in the cycle after Done.
- Out changes during BULK/LAST; it is valid only from Done onward.
- Sh_Out is combinational from Sh_In/Sh_Amount/Sh_Type. It is sampled at the end of each BULK/LAST cycle.

## Test plan
- LSL, Amount=1, In=0x8000_0001 → Out=0x0000_0002, CarryOut=1, Done 2 cycles after accept.
- LSR, Amount=32, In=0x8000_0000 → Out=0, CarryOut=1, latency 3. Then LSR, Amount=40 → Out=0, CarryOut=0, latency 4.
- ASR, Amount=200, In=0x8000_0000 → Out=0xFFFF_FFFF, CarryOut=1, latency 4. Sh_Amount sequence 31,1,1.
- ROR, Amount=8, In=0x1234_5678 → Out=0x7812_3456, CarryOut=0, latency 3. ROR, Amount=32, In=0x8000_0000 → Out=In, CarryOut=1, latency 1.
- Amount=0, any Type, CarryIn=1 → Out=In, CarryOut=1, latency 1. Start pulsed while Busy → ignored; Done pulses exactly once.
- Reset asserted mid-BULK (ASR 200) → Busy/Done/Out/CarryOut=0 immediately. A new LSL 4 of 0x0000_000F after release → 0x0000_00F0, CarryOut=0.

Source files
------------

// File: rtl/shift_sequencer_if.sv
// Request/result handshake and shared-barrel-shifter connection for shift_sequencer.
// The slave side is the sequencer. The master side is decode plus the shifter.
interface shift_sequencer_if;
    logic        Start;
    logic [1:0]  Type;
    logic [7:0]  Amount;
    logic [31:0] In;
    logic        CarryIn;
    logic        Busy;
    logic        Done;
    logic [31:0] Out;
    logic        CarryOut;
    logic [4:0]  Sh_Amount;
    logic [1:0]  Sh_Type;
    logic [31:0] Sh_In;
    logic [31:0] Sh_Out;

    modport master (
        output Start, Type, Amount, In, CarryIn, Sh_Out,
        input  Busy, Done, Out, CarryOut, Sh_Amount, Sh_Type, Sh_In
    );

    modport slave (
        input  Start, Type, Amount, In, CarryIn, Sh_Out,
        output Busy, Done, Out, CarryOut, Sh_Amount, Sh_Type, Sh_In
    );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle ARMv7 register-specified shift controller driving a shared 5-bit barrel shifter.
// Amounts beyond 31 are split into 31-bit bulk steps plus a final 1-bit step that yields the carry.
module shift_sequencer (
    input logic             CLK,
    input logic             Reset,
    shift_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BULK, LAST, DONE} state_t;

    localparam logic [1:0] T_LSL = 2'b00;
    localparam logic [1:0] T_ROR = 2'b11;

    state_t      state, state_nxt;
    logic [31:0] acc, acc_nxt;
    logic [1:0]  t, t_nxt;
    logic [5:0]  rem, rem_nxt;
    logic        c, c_nxt;
    logic [5:0]  eff;
    logic [5:0]  step;
    logic [4:0]  sh_amount;

    // Shifts of 33 or more give the same result and carry as 33, so clamp there.
    function automatic logic [5:0] eff_amount(input logic [1:0] ty, input logic [7:0] amt);
        if (ty == T_ROR)
            return {1'b0, amt[4:0]};
        else if (amt > 8'd33)
            return 6'd33;
        else
            return amt[5:0];
    endfunction

    function automatic logic [4:0] sat31(input logic [5:0] v);
        return (v > 6'd31) ? 5'd31 : v[4:0];
    endfunction

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            acc   <= '0;
            t     <= '0;
            rem   <= '0;
            c     <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            t     <= t_nxt;
            rem   <= rem_nxt;
            c     <= c_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        t_nxt     = t;
        rem_nxt   = rem;
        c_nxt     = c;
        sh_amount = 5'd0;
        eff       = eff_amount(bus.Type, bus.Amount);
        step      = {1'b0, sat31(rem)};

        unique case (state)
            IDLE: begin
                if (bus.Start) begin
                    acc_nxt = bus.In;
                    t_nxt   = bus.Type;
                    if (bus.Amount == 8'd0) begin
                        c_nxt     = bus.CarryIn;
                        state_nxt = DONE;
                    end else if (bus.Type == T_ROR && bus.Amount[4:0] == 5'd0) begin
                        c_nxt     = bus.In[31];
                        state_nxt = DONE;
                    end else begin
                        rem_nxt   = eff - 6'd1;
                        state_nxt = (eff > 6'd1) ? BULK : LAST;
                    end
                end
            end
            BULK: begin
                sh_amount = sat31(rem);
                acc_nxt   = bus.Sh_Out;
                rem_nxt   = rem - step;
                if (rem == step)
                    state_nxt = LAST;
            end
            LAST: begin
                // The bit shifted out by the final 1-bit step is the ARM carry.
                sh_amount = 5'd1;
                c_nxt     = (t == T_LSL) ? acc[31] : acc[0];
                acc_nxt   = bus.Sh_Out;
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.Busy      = (state != IDLE);
    assign bus.Done      = (state == DONE);
    assign bus.Out       = acc;
    assign bus.CarryOut  = c;
    assign bus.Sh_Amount = sh_amount;
    assign bus.Sh_Type   = t;
    assign bus.Sh_In     = acc;
endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: models the shared barrel shifter and checks results against
// ARM register-shift semantics computed directly from the shift amount.
module tb_shift_sequencer;
    logic CLK = 1'b0;
    logic Reset = 1'b1;

    shift_sequencer_if bus ();

    shift_sequencer dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int sh_log[$];

    // Shared 5-bit barrel shifter (environment component)
    function automatic logic [31:0] barrel(input logic [31:0] x, input logic [4:0] a, input logic [1:0] ty);
        logic signed [31:0] sx;
        sx = x;
        case (ty)
            2'b00:   return x << a;
            2'b01:   return x >> a;
            2'b10:   return sx >>> a;
            default: return (a == 5'd0) ? x : ((x >> a) | (x << (6'd32 - {1'b0, a})));
        endcase
    endfunction

    assign bus.Sh_Out = barrel(bus.Sh_In, bus.Sh_Amount, bus.Sh_Type);

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ARM register-shift reference: result, carry, latency and total shifted distance
    task automatic ref_model(input logic [1:0] ty, input logic [7:0] amt, input logic [31:0] x,
                             input logic cin, output logic [31:0] out, output logic c,
                             output int lat, output int shsum);
        logic [63:0]        u;
        logic signed [63:0] s;
        int                 e;
        int                 r;
        e = (ty == 2'b11) ? int'(amt[4:0]) : ((amt > 8'd33) ? 33 : int'(amt));
        r = int'(amt[4:0]);
        out = x;
        c = cin;
        if (amt == 8'd0) begin
            out = x; c = cin;
        end else begin
            case (ty)
                2'b00: begin
                    if (amt > 8'd32) begin out = 0; c = 0; end
                    else begin u = {32'b0, x} << amt; out = u[31:0]; c = u[32]; end
                end
                2'b01: begin
                    if (amt > 8'd32) begin out = 0; c = 0; end
                    else begin u = {x, 32'b0} >> amt; out = u[63:32]; c = u[31]; end
                end
                2'b10: begin
                    s = {x, 32'b0};
                    s = s >>> ((amt > 8'd32) ? 32 : int'(amt));
                    out = s[63:32]; c = s[31];
                end
                default: begin
                    out = (r == 0) ? x : ((x >> r) | (x << (32 - r)));
                    c = out[31];
                end
            endcase
        end
        if (amt == 8'd0 || (ty == 2'b11 && r == 0)) begin
            lat = 1; shsum = 0;
        end else begin
            lat = (e - 1 + 30) / 31 + 2; shsum = e;
        end
    endtask

    task automatic run_op(input logic [1:0] ty, input logic [7:0] amt, input logic [31:0] x,
                          input logic cin, input bit poke,
                          output logic [31:0] got_out, output logic got_c, output int got_lat);
        logic [31:0] eo;
        logic        ec;
        int          el, es, cyc, ssum;
        bit          seen;
        ref_model(ty, amt, x, cin, eo, ec, el, es);
        sh_log.delete();
        @(negedge CLK);
        bus.Start = 1'b1; bus.Type = ty; bus.Amount = amt; bus.In = x; bus.CarryIn = cin;
        @(posedge CLK);
        #1;
        if (poke) begin
            bus.Start = 1'b1; bus.Type = 2'($urandom); bus.Amount = 8'($urandom);
            bus.In = $urandom; bus.CarryIn = 1'($urandom);
        end else begin
            bus.Start = 1'b0;
        end
        check_val("busy_after_accept", 64'(bus.Busy), 64'd1);
        cyc = 1; ssum = 0; seen = 0;
        while (!seen && cyc <= 8) begin
            if (bus.Done) begin
                seen = 1;
            end else begin
                ssum += int'(bus.Sh_Amount);
                sh_log.push_back(int'(bus.Sh_Amount));
                @(posedge CLK);
                #1;
                cyc++;
            end
        end
        bus.Start = 1'b0;
        got_out = bus.Out; got_c = bus.CarryOut; got_lat = cyc;
        if (!seen) begin
            check_val("done_timeout", 64'd0, 64'd1);
        end else begin
            check_val("latency", 64'(cyc), 64'(el));
            check_val("out", 64'(bus.Out), 64'(eo));
            check_val("carry", 64'(bus.CarryOut), 64'(ec));
            check_val("shift_sum", 64'(ssum), 64'(es));
            @(posedge CLK);
            #1;
            check_val("done_once", 64'(bus.Done), 64'd0);
            check_val("busy_idle", 64'(bus.Busy), 64'd0);
            check_val("out_hold", 64'(bus.Out), 64'(eo));
            check_val("carry_hold", 64'(bus.CarryOut), 64'(ec));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] o;
        logic        c;
        int          l;
        logic [7:0]  amt;
        bus.Start = 0; bus.Type = 0; bus.Amount = 0; bus.In = 0; bus.CarryIn = 0;

        #12;
        check_val("rst_busy", 64'(bus.Busy), 64'd0);
        check_val("rst_done", 64'(bus.Done), 64'd0);
        check_val("rst_out", 64'(bus.Out), 64'd0);
        check_val("rst_carry", 64'(bus.CarryOut), 64'd0);
        check_val("rst_sh_amount", 64'(bus.Sh_Amount), 64'd0);
        check_val("rst_sh_type", 64'(bus.Sh_Type), 64'd0);
        @(negedge CLK);
        Reset = 1'b0;

        run_op(2'b00, 8'd1, 32'h8000_0001, 1'b0, 0, o, c, l);
        check_val("lsl1_out", 64'(o), 64'h2);
        check_val("lsl1_c", 64'(c), 64'd1);
        check_val("lsl1_lat", 64'(l), 64'd2);

        run_op(2'b01, 8'd32, 32'h8000_0000, 1'b0, 0, o, c, l);
        check_val("lsr32_out", 64'(o), 64'h0);
        check_val("lsr32_c", 64'(c), 64'd1);
        check_val("lsr32_lat", 64'(l), 64'd3);
        run_op(2'b01, 8'd40, 32'h8000_0000, 1'b1, 0, o, c, l);
        check_val("lsr40_out", 64'(o), 64'h0);
        check_val("lsr40_c", 64'(c), 64'd0);
        check_val("lsr40_lat", 64'(l), 64'd4);

        run_op(2'b10, 8'd200, 32'h8000_0000, 1'b0, 1, o, c, l);
        check_val("asr200_out", 64'(o), 64'hFFFF_FFFF);
        check_val("asr200_c", 64'(c), 64'd1);
        check_val("asr200_lat", 64'(l), 64'd4);
        check_val("asr200_steps", 64'(sh_log.size()), 64'd3);
        if (sh_log.size() == 3) begin
            check_val("asr200_sh0", 64'(sh_log[0]), 64'd31);
            check_val("asr200_sh1", 64'(sh_log[1]), 64'd1);
            check_val("asr200_sh2", 64'(sh_log[2]), 64'd1);
        end

        run_op(2'b11, 8'd8, 32'h1234_5678, 1'b1, 0, o, c, l);
        check_val("ror8_out", 64'(o), 64'h7812_3456);
        check_val("ror8_c", 64'(c), 64'd0);
        check_val("ror8_lat", 64'(l), 64'd3);
        run_op(2'b11, 8'd32, 32'h8000_0000, 1'b0, 0, o, c, l);
        check_val("ror32_out", 64'(o), 64'h8000_0000);
        check_val("ror32_c", 64'(c), 64'd1);
        check_val("ror32_lat", 64'(l), 64'd1);

        for (int ty = 0; ty < 4; ty++) begin
            run_op(2'(ty), 8'd0, 32'hA5C3_0F96, 1'b1, ty[0], o, c, l);
            check_val("amt0_out", 64'(o), 64'hA5C3_0F96);
            check_val("amt0_c", 64'(c), 64'd1);
            check_val("amt0_lat", 64'(l), 64'd1);
        end

        // Abort an ASR 200 while it is in its bulk steps
        @(negedge CLK);
        bus.Start = 1'b1; bus.Type = 2'b10; bus.Amount = 8'd200; bus.In = 32'h8000_0000; bus.CarryIn = 1'b0;
        @(posedge CLK);
        #1;
        bus.Start = 1'b0;
        @(posedge CLK);
        #1;
        Reset = 1'b1;
        #1;
        check_val("abort_busy", 64'(bus.Busy), 64'd0);
        check_val("abort_done", 64'(bus.Done), 64'd0);
        check_val("abort_out", 64'(bus.Out), 64'd0);
        check_val("abort_carry", 64'(bus.CarryOut), 64'd0);
        check_val("abort_sh_amount", 64'(bus.Sh_Amount), 64'd0);
        @(negedge CLK);
        Reset = 1'b0;
        run_op(2'b00, 8'd4, 32'h0000_000F, 1'b0, 0, o, c, l);
        check_val("post_rst_out", 64'(o), 64'hF0);
        check_val("post_rst_c", 64'(c), 64'd0);

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 6))
                0: amt = 8'd0;
                1: amt = 8'd1;
                2: amt = 8'd31;
                3: amt = 8'd32;
                4: amt = 8'd33;
                5: amt = 8'($urandom_range(2, 40));
                default: amt = 8'($urandom);
            endcase
            run_op(2'($urandom), amt, $urandom, 1'($urandom), bit'($urandom_range(0, 1)), o, c, l);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
